// File: rtl/spi_slave_responder.sv
// Mode-0 SPI slave that hands received bytes to a valid/ready stream and shifts out bytes from a one-deep holding register.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first transfers in both directions (default MSB-first).
module spi_slave_responder #(
    parameter logic [7:0] DEFAULT_TX  = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       io_systemClk,
    input  logic       io_systemReset,
    input  logic       spi_sclk,
    input  logic       spi_ss,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_overrun,
    output logic       tx_underrun
);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic       sclk_d, ss_d;
    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;
    logic [7:0] tx_shift, tx_shifted, tx_hold;
    logic       miso_bit;
    logic       enter, byte_done, boundary, capture;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;

    // Synchronisers reset low so a held-low SS never produces a false falling edge.
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_byte    = {mosi_s, rx_shift};
    assign tx_shifted = {1'b0, tx_shift[7:1]};
    assign miso_bit   = tx_shift[0];
`else
    assign rx_byte    = {rx_shift, mosi_s};
    assign tx_shifted = {tx_shift[6:0], 1'b0};
    assign miso_bit   = tx_shift[7];
`endif

    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) state <= WAIT_IDLE;
        else                state <= next_state;
    end

    always_comb begin
        next_state  = state;
        spi_miso_oe = 1'b0;
        spi_miso    = 1'b0;
        case (state)
            WAIT_IDLE: if (ss_s) next_state = IDLE;
            IDLE:      if (ss_fall) next_state = ACTIVE;
            ACTIVE: begin
                spi_miso_oe = 1'b1;
                spi_miso    = miso_bit;
                if (ss_rise) next_state = IDLE;
            end
            default:   next_state = WAIT_IDLE;
        endcase
    end

    assign enter     = (state == IDLE) && ss_fall;
    assign byte_done = (state == ACTIVE) && !ss_rise && sclk_rise && (bit_cnt == 3'd7);
    assign boundary  = enter || byte_done;
    assign capture   = tx_valid && tx_ready;

    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_hold     <= '0;
            tx_ready    <= 1'b1;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;

            if (enter) begin
                bit_cnt <= '0;
            end else if (state == ACTIVE) begin
                if (ss_rise) begin
                    bit_cnt <= '0;
                end else begin
                    if (sclk_rise) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
                        rx_shift <= rx_byte[7:1];
`else
                        rx_shift <= rx_byte[6:0];
`endif
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    // The fall right after a boundary keeps bit 7 of the fresh byte on the wire.
                    if (sclk_fall && bit_cnt != 3'd0) tx_shift <= tx_shifted;
                end
            end

            if (boundary) begin
                if (!tx_ready) begin
                    tx_shift <= tx_hold;
                    tx_ready <= 1'b1;
                end else begin
                    tx_shift    <= DEFAULT_TX;
                    tx_underrun <= 1'b1;
                end
            end

            // Capture only happens while empty, so it never collides with the refill above.
            if (capture) begin
                tx_hold  <= tx_data;
                tx_ready <= 1'b0;
            end

            if (byte_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_byte;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Scoreboard bench for spi_slave_responder: stimulus queues expected rx bytes, a monitor pops them on each rx handshake.
module tb_spi_slave_responder;

    localparam time HP = 60ns;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0, ss = 1'b0, mosi = 1'b0;
    logic       miso, miso_oe;
    logic       rx_valid, rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       tx_valid = 1'b0, tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic       rx_overrun, tx_underrun;

    int tests = 0, fails = 0;
    int ovr_cnt = 0, und_cnt = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] got;

    always #5ns clk = ~clk;

    spi_slave_responder dut (
        .io_systemClk(clk), .io_systemReset(rst),
        .spi_sclk(sclk), .spi_ss(ss), .spi_mosi(mosi),
        .spi_miso(miso), .spi_miso_oe(miso_oe),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun)
    );

    // Byte as it appears when the master reads/writes MSB-first on the wire.
    function automatic logic [7:0] wire_of(input logic [7:0] b);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
`else
        return b;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rx handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_overrun)  ovr_cnt++;
            if (tx_underrun) und_cnt++;
            if (rx_valid && rx_ready) begin
                tests++;
                if (rx_exp.size() == 0) begin
                    fails++;
                    $display("FAIL rx_unexpected: got %0h expected no byte", rx_data);
                end else begin
                    logic [7:0] e;
                    e = rx_exp.pop_front();
                    if (rx_data !== e) begin
                        fails++;
                        $display("FAIL rx_data: got %0h expected %0h", rx_data, e);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            #HP sclk = 1'b1;
            r[i] = miso;
            #HP sclk = 1'b0;
        end
    endtask

    task automatic ss_low();
        ss = 1'b0;
        #HP;
    endtask

    task automatic ss_high();
        #HP ss = 1'b1;
        #(2*HP);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data = b;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        check("tx_ready_after_capture", tx_ready, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with SS held low
        cyc(3);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_pulses", {rx_overrun, tx_underrun}, 0);
        rst = 1'b0;
        cyc(2);

        // Frame already in progress at reset release: must be ignored
        spi_byte(8'h55, got);
        spi_byte(8'hAA, got);
        check("midframe_oe", miso_oe, 0);
        check("midframe_rx_valid", rx_valid, 0);
        ss_high();

        // Preloaded A5 out, 3C in
        push_tx(8'hA5);
        ss = 1'b0;
        cyc(4);
        check("oe_after_ss_fall", miso_oe, 1);
        check("tx_ready_after_ss_fall", tx_ready, 1);
        #HP;
        rx_exp.push_back(wire_of(8'h3C));
        spi_byte(8'h3C, got);
        check("miso_A5", got, wire_of(8'hA5));
        ss_high();
        check("oe_after_ss_rise", miso_oe, 0);

        // Three bytes while the consumer stalls: first held, two overruns
        rx_ready = 1'b0;
        ovr_cnt = 0;
        rx_exp.push_back(wire_of(8'h11));
        ss_low();
        spi_byte(8'h11, got);
        spi_byte(8'h22, got);
        spi_byte(8'h33, got);
        ss_high();
        check("overrun_count", ovr_cnt, 2);
        check("held_rx_valid", rx_valid, 1);
        check("held_rx_data", rx_data, wire_of(8'h11));
        rx_ready = 1'b1;
        cyc(2);
        check("rx_valid_drained", rx_valid, 0);

        // Empty holding register: DEFAULT_TX then a late-fed 5A
        und_cnt = 0;
        rx_exp.push_back(wire_of(8'h00));
        rx_exp.push_back(wire_of(8'hFF));
        ss_low();
        fork
            spi_byte(8'h00, got);
            begin cyc(20); push_tx(8'h5A); end
        join
        check("miso_default", got, 8'hFF);
        check("underrun_once", und_cnt, 1);
        spi_byte(8'hFF, got);
        check("miso_5A", got, wire_of(8'h5A));
        ss_high();

        // Aborted byte after 5 edges, then a clean C3
        ss_low();
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1;
            #HP sclk = 1'b1;
            #HP sclk = 1'b0;
        end
        ss_high();
        check("abort_rx_valid", rx_valid, 0);
        rx_exp.push_back(wire_of(8'hC3));
        ss_low();
        spi_byte(8'hC3, got);
        check("miso_after_abort", got, 8'hFF);
        ss_high();

`ifdef SPI_SLAVE_LSB_FIRST_EN
        // LSB-first: 01 goes out as wire 80, wire 80 comes in as 01
        push_tx(8'h01);
        rx_exp.push_back(8'h01);
        ss_low();
        spi_byte(8'h80, got);
        check("lsb_first_bit", got[7], 1);
        check("lsb_miso", got, 8'h80);
        ss_high();
`endif

        cyc(5);
        check("scoreboard_empty", rx_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
